// File: rtl/tos_stack_pkg.sv
// Shared definitions for the top-of-stack register file.
//   delta_e   : op_delta encodings (none / push / pop1 / pop2)
//   delta_inc : signed stack-pointer increment for each encoding
package tos_stack_pkg;

   typedef enum logic [1:0] {
      DELTA_NONE = 2'b00,
      DELTA_PUSH = 2'b01,
      DELTA_POP2 = 2'b10,
      DELTA_POP1 = 2'b11
   } delta_e;

   function automatic int delta_inc(input delta_e d);
      case (d)
         DELTA_PUSH: return 1;
         DELTA_POP1: return -1;
         DELTA_POP2: return -2;
         default:    return 0;
      endcase
   endfunction

endpackage

// File: rtl/tos_stack_ram.sv
// Backing store for the entries below top-of-stack.
//   clk              : rising-edge clock for the write port
//   we/waddr/wdata   : synchronous write port
//   raddr_a/rdata_a  : asynchronous read port (second entry, sp)
//   raddr_b/rdata_b  : asynchronous read port (third entry, sp-1)
// Contents are intentionally not reset.
module tos_stack_ram #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16,
   parameter int PTRW  = 4
) (
   input  logic             clk,
   input  logic             we,
   input  logic [PTRW-1:0]  waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [PTRW-1:0]  raddr_a,
   input  logic [PTRW-1:0]  raddr_b,
   output logic [WIDTH-1:0] rdata_a,
   output logic [WIDTH-1:0] rdata_b
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/tos_stack.sv
// Stack with a registered top-of-stack (T) and a RAM holding the rest.
//   clk, reset          : rising-edge clock, async active-low reset
//   op_valid/op_delta   : apply a pointer move (none/push/pop1/pop2)
//   op_write/op_data    : load op_data into T as part of the op
//   clear_flags         : clear sticky overflow/underflow
//   top, next           : T and second entry mem[sp]
//   sp, depth           : memory pointer and entries held in memory
//   empty, full         : depth==0 / depth==DEPTH
//   overflow, underflow : sticky error flags
// WRAP=0 drops faulting ops; WRAP=1 executes them with depth saturating.
module tos_stack
   import tos_stack_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16,
   parameter int WRAP  = 0,
   localparam int PTRW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             op_valid,
   input  logic [1:0]       op_delta,
   input  logic             op_write,
   input  logic [WIDTH-1:0] op_data,
   input  logic             clear_flags,
   output logic [WIDTH-1:0] top,
   output logic [WIDTH-1:0] next,
   output logic [PTRW-1:0]  sp,
   output logic [PTRW:0]    depth,
   output logic             empty,
   output logic             full,
   output logic             overflow,
   output logic             underflow
);

   localparam logic [PTRW:0] DEPTH_MAX = (PTRW+1)'(DEPTH);
   localparam logic [PTRW:0] ONE       = (PTRW+1)'(1);
   localparam logic [PTRW:0] TWO       = (PTRW+1)'(2);

   logic [WIDTH-1:0] t_q, t_nxt;
   logic [PTRW-1:0]  sp_q, sp_nxt;
   logic [PTRW:0]    depth_q, depth_nxt;
   logic             ovf_q, unf_q;
   logic             ovf_fault, unf_fault, exec;
   logic             we;
   logic [PTRW:0]    pop_k;
   logic [WIDTH-1:0] rd_a, rd_b, rd_b_eff, t_src;
   delta_e           delta;

   assign delta = delta_e'(op_delta);

   tos_stack_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .PTRW  (PTRW)
   ) u_ram (
      .clk     (clk),
      .we      (we),
      .waddr   (sp_q + PTRW'(1)),
      .wdata   (t_q),
      .raddr_a (sp_q),
      .raddr_b (sp_q - PTRW'(1)),
      .rdata_a (rd_a),
      .rdata_b (rd_b)
   );

   // In guarded mode entries outside the live region read as zero.
   assign rd_b_eff = (WRAP == 0 && depth_q < TWO) ? '0 : rd_b;
   assign next     = (WRAP == 0 && depth_q == '0) ? '0 : rd_a;

   always_comb begin
      pop_k = '0;
      case (delta)
         DELTA_POP1: pop_k = ONE;
         DELTA_POP2: pop_k = TWO;
         default:    pop_k = '0;
      endcase
   end

   assign ovf_fault = op_valid && (delta == DELTA_PUSH) && (depth_q == DEPTH_MAX);
   assign unf_fault = op_valid && (depth_q < pop_k);
   assign exec      = op_valid && ((WRAP != 0) || !(ovf_fault || unf_fault));

   always_comb begin
      t_nxt     = t_q;
      sp_nxt    = sp_q;
      depth_nxt = depth_q;
      we        = 1'b0;
      t_src     = t_q;
      case (delta)
         DELTA_POP1: t_src = rd_a;
         DELTA_POP2: t_src = rd_b_eff;
         default:    t_src = t_q;
      endcase
      if (exec) begin
         sp_nxt = sp_q + PTRW'(delta_inc(delta));
         t_nxt  = op_write ? op_data : t_src;
         if (delta == DELTA_PUSH) begin
            we        = 1'b1;
            depth_nxt = (depth_q == DEPTH_MAX) ? depth_q : depth_q + ONE;
         end else if (depth_q < pop_k) begin
            depth_nxt = '0;
         end else begin
            depth_nxt = depth_q - pop_k;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         t_q     <= '0;
         sp_q    <= '0;
         depth_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         t_q     <= t_nxt;
         sp_q    <= sp_nxt;
         depth_q <= depth_nxt;
         // A fault in the same cycle as clear_flags wins.
         ovf_q   <= ovf_fault || (ovf_q && !clear_flags);
         unf_q   <= unf_fault || (unf_q && !clear_flags);
      end
   end

   assign top       = t_q;
   assign sp        = sp_q;
   assign depth     = depth_q;
   assign empty     = (depth_q == '0);
   assign full      = (depth_q == DEPTH_MAX);
   assign overflow  = ovf_q;
   assign underflow = unf_q;

endmodule

// File: tb/tb_tos_stack.sv
// Directed bench for tos_stack (WIDTH=16, DEPTH=4), guarded and circular.
module tb_tos_stack;

   logic        clk;
   logic        reset;
   logic        op_valid;
   logic [1:0]  op_delta;
   logic        op_write;
   logic [15:0] op_data;
   logic        clear_flags;

   logic [15:0] g_top, g_next, c_top, c_next;
   logic [1:0]  g_sp, c_sp;
   logic [2:0]  g_depth, c_depth;
   logic        g_empty, g_full, g_ovf, g_unf;
   logic        c_empty, c_full, c_ovf, c_unf;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [1:0] D_NONE = 2'b00;
   localparam logic [1:0] D_PUSH = 2'b01;
   localparam logic [1:0] D_POP2 = 2'b10;
   localparam logic [1:0] D_POP1 = 2'b11;

   tos_stack #(.WIDTH(16), .DEPTH(4), .WRAP(0)) dut_g (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_delta(op_delta),
      .op_write(op_write), .op_data(op_data), .clear_flags(clear_flags),
      .top(g_top), .next(g_next), .sp(g_sp), .depth(g_depth),
      .empty(g_empty), .full(g_full), .overflow(g_ovf), .underflow(g_unf)
   );

   tos_stack #(.WIDTH(16), .DEPTH(4), .WRAP(1)) dut_c (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_delta(op_delta),
      .op_write(op_write), .op_data(op_data), .clear_flags(clear_flags),
      .top(c_top), .next(c_next), .sp(c_sp), .depth(c_depth),
      .empty(c_empty), .full(c_full), .overflow(c_ovf), .underflow(c_unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [1:0]  d;
      logic        w;
      logic [15:0] data;
      logic        clr;
      logic [15:0] e_top;
      logic [15:0] e_next;
      logic [1:0]  e_sp;
      logic [2:0]  e_depth;
      logic        e_ovf;
      logic        e_unf;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic v, logic [1:0] d, logic w, logic [15:0] data,
                               logic clr, logic [15:0] e_top, logic [15:0] e_next,
                               logic [1:0] e_sp, logic [2:0] e_depth,
                               logic e_ovf, logic e_unf);
      vec_t r;
      r.v = v; r.d = d; r.w = w; r.data = data; r.clr = clr;
      r.e_top = e_top; r.e_next = e_next; r.e_sp = e_sp; r.e_depth = e_depth;
      r.e_ovf = e_ovf; r.e_unf = e_unf;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] d, input logic w,
                        input logic [15:0] data, input logic clr);
      op_valid = v; op_delta = d; op_write = w; op_data = data; clear_flags = clr;
   endtask

   task automatic step(input logic v, input logic [1:0] d, input logic w,
                       input logic [15:0] data, input logic clr);
      drive(v, d, w, data, clr);
      @(posedge clk);
      #1;
      drive(1'b0, D_NONE, 1'b0, 16'h0, 1'b0);
   endtask

   task automatic chk_guard_state(input string tag, input logic [15:0] e_top,
                                  input logic [15:0] e_next, input logic [1:0] e_sp,
                                  input logic [2:0] e_depth, input logic e_ovf,
                                  input logic e_unf);
      chk({tag, " top"},   32'(g_top),   32'(e_top));
      chk({tag, " next"},  32'(g_next),  32'(e_next));
      chk({tag, " sp"},    32'(g_sp),    32'(e_sp));
      chk({tag, " depth"}, 32'(g_depth), 32'(e_depth));
      chk({tag, " empty"}, 32'(g_empty), 32'(e_depth == 3'd0));
      chk({tag, " full"},  32'(g_full),  32'(e_depth == 3'd4));
      chk({tag, " ovf"},   32'(g_ovf),   32'(e_ovf));
      chk({tag, " unf"},   32'(g_unf),   32'(e_unf));
   endtask

   initial begin
      reset = 1'b0;
      drive(1'b0, D_NONE, 1'b0, 16'h0, 1'b0);
      #12;
      chk_guard_state("reset", 16'h0, 16'h0, 2'd0, 3'd0, 1'b0, 1'b0);
      chk("reset c_top",   32'(c_top),   32'h0);
      chk("reset c_depth", 32'(c_depth), 32'h0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      //              v   delta  w   data    clr  top      next     sp    depth ovf  unf
      vecs.push_back(mk(1, D_PUSH, 1, 16'h0011, 0, 16'h0011, 16'h0000, 2'd1, 3'd1, 0, 0));
      vecs.push_back(mk(1, D_PUSH, 1, 16'h0022, 0, 16'h0022, 16'h0011, 2'd2, 3'd2, 0, 0));
      vecs.push_back(mk(1, D_PUSH, 1, 16'h0033, 0, 16'h0033, 16'h0022, 2'd3, 3'd3, 0, 0));
      vecs.push_back(mk(1, D_POP1, 0, 16'h0000, 0, 16'h0022, 16'h0011, 2'd2, 3'd2, 0, 0));
      vecs.push_back(mk(1, D_PUSH, 1, 16'h0033, 0, 16'h0033, 16'h0022, 2'd3, 3'd3, 0, 0));
      vecs.push_back(mk(1, D_POP2, 0, 16'h0000, 0, 16'h0011, 16'h0000, 2'd1, 3'd1, 0, 0));
      vecs.push_back(mk(1, D_NONE, 1, 16'hBEEF, 0, 16'hBEEF, 16'h0000, 2'd1, 3'd1, 0, 0));
      vecs.push_back(mk(0, D_PUSH, 1, 16'h1234, 0, 16'hBEEF, 16'h0000, 2'd1, 3'd1, 0, 0));
      vecs.push_back(mk(1, D_POP2, 0, 16'h0000, 0, 16'hBEEF, 16'h0000, 2'd1, 3'd1, 0, 1));
      vecs.push_back(mk(0, D_NONE, 0, 16'h0000, 1, 16'hBEEF, 16'h0000, 2'd1, 3'd1, 0, 0));
      vecs.push_back(mk(1, D_NONE, 1, 16'h00AA, 0, 16'h00AA, 16'h0000, 2'd1, 3'd1, 0, 0));
      vecs.push_back(mk(1, D_PUSH, 0, 16'h0000, 0, 16'h00AA, 16'h00AA, 2'd2, 3'd2, 0, 0));
      vecs.push_back(mk(1, D_POP1, 0, 16'h0000, 0, 16'h00AA, 16'h0000, 2'd1, 3'd1, 0, 0));
      vecs.push_back(mk(1, D_POP1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 2'd0, 3'd0, 0, 0));
      vecs.push_back(mk(1, D_POP1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 2'd0, 3'd0, 0, 1));
      vecs.push_back(mk(1, D_POP1, 1, 16'h5555, 1, 16'h0000, 16'h0000, 2'd0, 3'd0, 0, 1));
      vecs.push_back(mk(0, D_NONE, 0, 16'h0000, 1, 16'h0000, 16'h0000, 2'd0, 3'd0, 0, 0));
      vecs.push_back(mk(1, D_PUSH, 1, 16'h0001, 0, 16'h0001, 16'h0000, 2'd1, 3'd1, 0, 0));
      vecs.push_back(mk(1, D_PUSH, 1, 16'h0002, 0, 16'h0002, 16'h0001, 2'd2, 3'd2, 0, 0));
      vecs.push_back(mk(1, D_PUSH, 1, 16'h0003, 0, 16'h0003, 16'h0002, 2'd3, 3'd3, 0, 0));
      vecs.push_back(mk(1, D_PUSH, 1, 16'h0004, 0, 16'h0004, 16'h0003, 2'd0, 3'd4, 0, 0));
      vecs.push_back(mk(1, D_PUSH, 1, 16'h0005, 0, 16'h0004, 16'h0003, 2'd0, 3'd4, 1, 0));
      vecs.push_back(mk(1, D_POP2, 0, 16'h0000, 0, 16'h0002, 16'h0001, 2'd2, 3'd2, 1, 0));
      vecs.push_back(mk(1, D_POP2, 0, 16'h0000, 0, 16'h0000, 16'h0000, 2'd0, 3'd0, 1, 0));
      vecs.push_back(mk(1, D_POP1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 2'd0, 3'd0, 1, 1));

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].v, vecs[i].d, vecs[i].w, vecs[i].data, vecs[i].clr);
         chk_guard_state($sformatf("vec%0d", i), vecs[i].e_top, vecs[i].e_next,
                         vecs[i].e_sp, vecs[i].e_depth, vecs[i].e_ovf, vecs[i].e_unf);
      end

      // Asynchronous reset between clock edges, with an op pending.
      drive(1'b1, D_PUSH, 1'b1, 16'h7777, 1'b0);
      #3;
      reset = 1'b0;
      #1;
      chk_guard_state("async_rst", 16'h0, 16'h0, 2'd0, 3'd0, 1'b0, 1'b0);
      chk("async_rst c_ovf",   32'(c_ovf),   32'h0);
      chk("async_rst c_empty", 32'(c_empty), 32'h1);
      drive(1'b0, D_NONE, 1'b0, 16'h0, 1'b0);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Circular mode: fifth push overwrites the oldest slot and wraps sp.
      for (int k = 1; k <= 5; k++) step(1'b1, D_PUSH, 1'b1, 16'(k), 1'b0);
      chk("wrap push top",   32'(c_top),   32'h5);
      chk("wrap push next",  32'(c_next),  32'h4);
      chk("wrap push sp",    32'(c_sp),    32'h1);
      chk("wrap push depth", 32'(c_depth), 32'h4);
      chk("wrap push full",  32'(c_full),  32'h1);
      chk("wrap push ovf",   32'(c_ovf),   32'h1);

      step(1'b1, D_POP2, 1'b0, 16'h0, 1'b0);
      chk("wrap pop2a top",   32'(c_top),   32'h3);
      chk("wrap pop2a sp",    32'(c_sp),    32'h3);
      chk("wrap pop2a depth", 32'(c_depth), 32'h2);
      step(1'b1, D_POP2, 1'b0, 16'h0, 1'b0);
      chk("wrap pop2b top",   32'(c_top),   32'h1);
      chk("wrap pop2b sp",    32'(c_sp),    32'h1);
      chk("wrap pop2b depth", 32'(c_depth), 32'h0);
      step(1'b1, D_POP1, 1'b0, 16'h0, 1'b0);
      chk("wrap unf top",   32'(c_top),   32'h4);
      chk("wrap unf sp",    32'(c_sp),    32'h0);
      chk("wrap unf depth", 32'(c_depth), 32'h0);
      chk("wrap unf empty", 32'(c_empty), 32'h1);
      chk("wrap unf flag",  32'(c_unf),   32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tos_stack.md
TOS_STACK -- requirements
Module: tos_stack

Interface
REQ-001 Parameter WIDTH, default 16: data width in bits.
REQ-002 Parameter DEPTH, default 16: memory entries below top-of-stack (power of two, >=4); PTRW = log2(DEPTH).
REQ-003 Parameter WRAP, default 0: 0 = guarded mode (faulting ops dropped); 1 = circular mode (faulting ops executed, pointer wraps).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 op_valid  input  1  an op is applied this cycle.
REQ-007 op_delta  input  2  pointer move: 00 none, 01 push (+1), 11 pop1 (-1), 10 pop2 (-2).
REQ-008 op_write  input  1  load op_data into top.
REQ-009 op_data  input  WIDTH  new top value.
REQ-010 clear_flags  input  1  clears sticky error flags.
REQ-011 top  output  WIDTH  registered top-of-stack (T).
REQ-012 next  output  WIDTH  second entry (N) = mem[sp].
REQ-013 sp  output  PTRW  memory pointer.
REQ-014 depth  output  PTRW+1  entries held in memory (0..DEPTH).
REQ-015 empty, full  output  1 each  depth==0 / depth==DEPTH.
REQ-016 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 No state changes when op_valid=0, except flag clearing.
REQ-018 Push: mem[sp+1] <= T; sp <= sp+1; depth +1; T <= op_write ? op_data : T (dup).
REQ-019 Pop1: sp <= sp-1; depth -1; T <= op_write ? op_data : mem[sp].
REQ-020 Pop2: sp <= sp-2; depth -2; T <= op_write ? op_data : mem[sp-1].
REQ-021 Delta none: T <= op_write ? op_data : T; sp, depth unchanged.
REQ-022 All effects visible on top/next/sp/depth one clock after the accepting edge; next is combinational from registered sp and memory.
REQ-023 Pointer arithmetic is modulo DEPTH.
REQ-024 Push with depth==DEPTH sets overflow; pop by k with depth<k sets underflow.
REQ-025 WRAP=0: a faulting op changes no state besides the flag, including T, memory, sp and depth.
REQ-026 WRAP=1: a faulting op executes fully, sp wraps, and depth saturates at DEPTH or 0.
REQ-027 WRAP=0 with depth==0: next drives 0.
REQ-028 WRAP=0 with depth==1: next drives 0 for the pop2 read source only; pop2 still faults.
REQ-029 clear_flags and a new fault in the same cycle: the flag ends set.
REQ-030 Memory write uses the pre-update sp+1; a read of the just-written slot returns the new value on the following cycle.

Reset
REQ-031 reset low asynchronously forces T=0, sp=0, depth=0, overflow=0, underflow=0.
REQ-032 Reset forces empty=1, full=0, and next=0 in WRAP=0.
REQ-033 Memory contents are not reset.
REQ-034 Reset deassertion is synchronised by the integrator; the first op is honoured on the first rising edge with reset high.
REQ-035 Reset mid-operation discards the op in flight; no partial memory write is required to be suppressed.

Structure
REQ-036 Shared package tos_stack_pkg holds the op_delta encodings DELTA_NONE, DELTA_PUSH, DELTA_POP1, DELTA_POP2.
REQ-037 The package holds a function returning the signed pointer increment for each encoding.
REQ-038 One sub-module, tos_stack_ram: DEPTH x WIDTH, one synchronous write port, two asynchronous read ports (sp, sp-1).
REQ-039 Top level holds T, sp, depth, flags and the control logic.

Verification (WIDTH=16, DEPTH=4)
REQ-040 Reset; push 0x0011, 0x0022, 0x0033 with write -> top=0x0033, next=0x0022, depth=3, sp=3.
REQ-041 From REQ-040 state, pop1 no write -> top=0x0022, next=0x0011, depth=2.
REQ-042 From REQ-040 state, pop2 no write -> top=0x0011, depth=1.
REQ-043 WRAP=0: five pushes of 1..5 -> fifth push sets overflow, top=4, depth=4, full=1.
REQ-044 WRAP=0, after REQ-043: pop2 x2 -> depth=0; third pop1 sets underflow and leaves top and sp unchanged.
REQ-045 WRAP=1: five pushes of 1..5 -> overflow=1, top=5, next=4, sp wraps to 1, depth=4.
REQ-046 clear_flags asserted the same cycle as a fault -> flag remains 1; the next cycle clear_flags alone -> flag 0.
REQ-047 Delta none with write 0xBEEF -> top=0xBEEF; depth and next unchanged.
REQ-048 Push without write while top=0x00AA -> top=0x00AA, next=0x00AA.
REQ-049 Reset asserted mid-sequence -> all outputs take reset values immediately, without waiting for clk.
